// File: rtl/dm_responder.sv
// Handshaked word-wide data-memory responder with WAIT_CYCLES wait states per access.
// Optional per-byte write strobes via the DM_BYTE_STROBE_EN macro (adds the be port).
module dm_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
`ifdef DM_BYTE_STROBE_EN
    input  logic [3:0]        be,
`endif
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [31:0]       r_rdata;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
`ifdef DM_BYTE_STROBE_EN
    logic [3:0]        r_be;
`endif
    logic              w_accept;
    logic              w_access;

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= 4'(WAIT_CYCLES);
            else if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_access && !r_we)
                r_rdata <= r_mem[r_addr];
        end
    end

    // Request registers carry data only; they are overwritten on every acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
`ifdef DM_BYTE_STROBE_EN
            r_be    <= be;
`endif
        end
    end

    // Gating with rst keeps a write caught by reset from ever being committed.
    always_ff @(posedge clk) begin
        if (rst && w_access && r_we) begin
`ifdef DM_BYTE_STROBE_EN
            for (int i = 0; i < 4; i++) begin
                if (r_be[i])
                    r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
            end
`else
            r_mem[r_addr] <= r_wdata;
`endif
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign ready = (r_state == S_RESP);
    assign rdata = r_rdata;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: transaction-level timing/memory model checked every
// cycle, plus literal expectations; a second zero-wait instance covers WAIT_CYCLES=0.
module tb_dm_responder;

    localparam int W = 2;
`ifdef DM_BYTE_STROBE_EN
    localparam bit STROBE = 1'b1;
`else
    localparam bit STROBE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        ready, busy;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [5:0]  addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic        ready0, busy0;
    logic [31:0] rdata0;

    int vectors = 0;
    int miscompares = 0;

    dm_responder #(.ADDR_W(6), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DM_BYTE_STROBE_EN
        .be(be),
`endif
        .ready(ready), .rdata(rdata), .busy(busy)
    );

    dm_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DM_BYTE_STROBE_EN
        .be(4'hF),
`endif
        .ready(ready0), .rdata(rdata0), .busy(busy0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes W+1 edges later; the next edge returns to idle.
    int          cyc = 0;
    int          m_due = 0;
    bit          m_pend = 1'b0, m_resp = 1'b0, m_rd_known = 1'b1;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_mem [64];
    bit          m_known [64];
    logic        mq_we;
    logic [5:0]  mq_a;
    logic [31:0] mq_d;
    logic [3:0]  mq_b;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_pend = 1'b0; m_resp = 1'b0; m_rdata = '0; m_rd_known = 1'b1;
        end else if (m_pend && cyc == m_due) begin
            m_pend = 1'b0;
            m_resp = 1'b1;
            if (mq_we) begin
                for (int i = 0; i < 4; i++)
                    if (mq_b[i]) m_mem[mq_a][8*i +: 8] = mq_d[8*i +: 8];
                if (mq_b == 4'hF) m_known[mq_a] = 1'b1;
            end else begin
                m_rdata    = m_mem[mq_a];
                m_rd_known = m_known[mq_a];
            end
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (!m_pend && req) begin
            mq_we = we; mq_a = addr; mq_d = wdata;
            mq_b  = STROBE ? be : 4'hF;
            m_pend = 1'b1;
            m_due  = cyc + W + 1;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_busy",  32'(busy),  32'(m_pend || m_resp));
            chk("model_ready", 32'(ready), 32'(m_resp));
            if (m_rd_known) chk("model_rdata", rdata, m_rdata);
        end
    end

    // Called on the falling edge right after an acceptance edge; lat counts that edge as 1.
    task automatic wait_rdy(output int lat, output logic [31:0] rd);
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rd = rdata;
        if (!ready) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: got no ready, expected one within 40 cycles");
        end
    endtask

    task automatic xact(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output int lat);
        @(negedge clk); req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        @(negedge clk); req = 1'b0;
        wait_rdy(lat, rd);
    endtask

    task automatic xact0(input logic w, input logic [5:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
        @(negedge clk); req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk);
        @(negedge clk); req0 = 1'b0;
        lat = 1;
        while (!ready0 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rd = rdata0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [5:0]  sw_a [4];
        logic [31:0] sw_d [4];
        sw_a = '{6'h3F, 6'h00, 6'h20, 6'h15};
        sw_d = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h80000001, 32'h7FFFFFFE};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rdata", rdata,      32'h0);
        rst = 1'b1;

        xact(1'b1, 6'h05, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("wr_latency", 32'(lat), 32'd4);
        xact(1'b0, 6'h05, 32'h0, 4'hF, rd, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_after_wr", rd, 32'hDEADBEEF);

        // Inputs changed and req dropped while the read is waiting.
        xact(1'b1, 6'h01, 32'hA5A5A5A5, 4'hF, rd, lat);
        xact(1'b1, 6'h02, 32'h5A5A5A5A, 4'hF, rd, lat);
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 6'h01;
        @(posedge clk);
        @(negedge clk); addr = 6'h02; req = 1'b0; we = 1'b1; wdata = 32'hFFFFFFFF;
        wait_rdy(lat, rd);
        chk("midchg_latency", 32'(lat), 32'd4);
        chk("midchg_rdata", rd, 32'hA5A5A5A5);
        xact(1'b0, 6'h02, 32'h0, 4'hF, rd, lat);
        chk("midchg_addr2_kept", rd, 32'h5A5A5A5A);

        // Reset while a write is still waiting.
        xact(1'b1, 6'h0A, 32'h00000011, 4'hF, rd, lat);
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 6'h0A; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk); req = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy",  32'(busy),  32'h0);
        chk("rstmid_ready", 32'(ready), 32'h0);
        chk("rstmid_rdata", rdata,      32'h0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        xact(1'b0, 6'h0A, 32'h0, 4'hF, rd, lat);
        chk("rstmid_not_committed", rd, 32'h00000011);

        // req held through the response: one idle cycle, then a second acceptance.
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 6'h05;
        @(posedge clk);
        @(negedge clk);
        wait_rdy(lat, rd);
        chk("held_first_latency", 32'(lat), 32'd4);
        @(negedge clk);
        chk("held_gap_busy",  32'(busy),  32'h0);
        chk("held_gap_ready", 32'(ready), 32'h0);
        @(negedge clk);
        chk("held_reaccept_busy", 32'(busy), 32'h1);
        req = 1'b0;
        wait_rdy(lat, rd);
        chk("held_second_latency", 32'(lat), 32'd4);
        chk("held_second_rdata", rd, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) xact(1'b1, sw_a[i], sw_d[i], 4'hF, rd, lat);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, sw_a[i], 32'h0, 4'hF, rd, lat);
            chk("sweep_rdata", rd, sw_d[i]);
        end

`ifdef DM_BYTE_STROBE_EN
        xact(1'b1, 6'h07, 32'h11223344, 4'hF, rd, lat);
        xact(1'b1, 6'h07, 32'hAABBCCDD, 4'b0101, rd, lat);
        xact(1'b0, 6'h07, 32'h0, 4'b0000, rd, lat);
        chk("strobe_0101", rd, 32'h11BB33DD);
        xact(1'b1, 6'h07, 32'h00000000, 4'b0000, rd, lat);
        chk("strobe_noop_latency", 32'(lat), 32'd4);
        xact(1'b0, 6'h07, 32'h0, 4'hF, rd, lat);
        chk("strobe_noop", rd, 32'h11BB33DD);
`endif

        xact0(1'b1, 6'h3F, 32'h12345678, rd, lat);
        chk("zw_wr_latency", 32'(lat), 32'd2);
        xact0(1'b0, 6'h3F, 32'h0, rd, lat);
        chk("zw_rd_latency", 32'(lat), 32'd2);
        chk("zw_rdata", rd, 32'h12345678);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Handshaked data-memory responder for the multi-cycle RV32 CPU. It accepts one word read or write per request from the CPU's load/store datapath and answers after a programmable number of wait states. It replaces the zero-wait synchronous RAM so that the control unit can be exercised against a stalling memory. Storage is a 2^ADDR_W × 32-bit word array that lives inside the block.

## Interface
- ADDR_W, 6, word-address width; depth = 2^ADDR_W words
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..15
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-low
- req  input  1  request valid; held high by the initiator until ready
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  ADDR_W  word address (CPU passes F[ADDR_W-1:0])
- wdata  input  32  write data (CPU passes B)
- be  input  4  byte enables; present only with DM_BYTE_STROBE_EN
- ready  output  1  one-cycle completion pulse
- rdata  output  32  read data; valid with ready, held until the next read completes
- busy  output  1  high from acceptance until ready inclusive

## Operation
- The FSM has three states, each with a named encoding:
  - IDLE: if req is high at the clock edge, latch we/addr/wdata(/be) into the request registers, load cnt=WAIT_CYCLES, go to WAIT. busy rises in this same cycle.
  - WAIT: if cnt==0, perform the access and go to RESP; else cnt←cnt−1.
  - RESP: ready=1 for exactly this cycle, then go to IDLE unconditionally.
- Access at WAIT→RESP:
  - Read: rdata←mem[addr_q].
  - Write: mem[addr_q]←wdata_q. rdata is unchanged.
- Only latched values are used. Changes on addr, wdata or we after acceptance are ignored.
- Deasserting req during WAIT does not abort the access. The transaction completes and ready still pulses.
- req high in RESP is not accepted. Acceptance happens in IDLE on the following cycle. The initiator must drop req on seeing ready, or it issues a second access.
- The address space is fully decoded. All 2^ADDR_W addresses are valid; there is no wrap or error condition.
- The array is not cleared by reset and holds its contents across reset.
- Outputs during reset: state=IDLE, cnt=0, ready=0, busy=0, rdata=32'h0. The pending request is discarded. A write still in WAIT when reset hits is never committed.

## Timing
- Request sampled at edge t0 → ready is high in cycle t0+WAIT_CYCLES+2. With WAIT_CYCLES=0, ready follows acceptance by 2 edges: IDLE→WAIT→RESP.
- Throughput is one access per WAIT_CYCLES+3 cycles when req is re-raised immediately after ready.
- busy = (state!=IDLE). ready = (state==RESP). Both are registered-state decodes with no combinational path from req.
- A read issued after a write to the same address returns the new data. No bypass is needed because accesses are serialized.
- cnt is 4 bits wide.

## Configuration
- DM_BYTE_STROBE_EN defined:
  - The be port exists and is latched at acceptance.
  - A write updates only bytes i where be_q[i]=1. be=4'b0000 is a no-op write but still completes with ready.
  - Reads ignore be.
- DM_BYTE_STROBE_EN undefined:
  - There is no be port.
  - Every write updates all 32 bits.

## Test plan
- Write then read, WAIT_CYCLES=2: write 32'hDEADBEEF to addr 6'h05, then read 6'h05. Each ready arrives exactly 4 cycles after acceptance; rdata=32'hDEADBEEF.
- Zero-wait build (WAIT_CYCLES=0): write 32'h12345678 to 6'h3F, then read 6'h3F. Ready comes 2 cycles after each acceptance; rdata=32'h12345678; the top address is accessible.
- Input change mid-transaction: accept a read of 6'h01 (holding 32'hA5A5A5A5). During WAIT, change addr to 6'h02, drop req, toggle we. ready still pulses; rdata=32'hA5A5A5A5; mem[6'h02] is unchanged.
- Reset mid-write: accept a write of 32'hFFFFFFFF to 6'h0A (old value 32'h00000011) and assert rst=0 during WAIT. Outputs are 0 and state is IDLE; a later read of 6'h0A returns 32'h00000011.
- Held req: keep req=1 through RESP. A second access is accepted exactly one cycle after ready, and busy is low for exactly that cycle.
- DM_BYTE_STROBE_EN: starting from 32'h11223344 at 6'h07, write 32'hAABBCCDD with be=4'b0101, then read. rdata=32'h11BB33DD.
